// File: rtl/cpu_pkg.sv
// Shared CPU decode definitions: opcode values, ALU operation classes and
// the control bundle carried from decode into execute.
package cpu_pkg;

   localparam int CPU_OPCODE_W = 7;
   localparam int CPU_ALUOP_W  = 2;

   // RV64 major opcodes recognised by the main decoder
   localparam logic [CPU_OPCODE_W-1:0] OPC_LOAD    = 7'b0000011;
   localparam logic [CPU_OPCODE_W-1:0] OPC_STORE   = 7'b0100011;
   localparam logic [CPU_OPCODE_W-1:0] OPC_OP      = 7'b0110011;
   localparam logic [CPU_OPCODE_W-1:0] OPC_OP32    = 7'b0111011;
   localparam logic [CPU_OPCODE_W-1:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [CPU_OPCODE_W-1:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [CPU_OPCODE_W-1:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [CPU_OPCODE_W-1:0] OPC_JAL     = 7'b1101111;
   localparam logic [CPU_OPCODE_W-1:0] OPC_JALR    = 7'b1100111;
   localparam logic [CPU_OPCODE_W-1:0] OPC_LUI     = 7'b0110111;
   localparam logic [CPU_OPCODE_W-1:0] OPC_AUIPC   = 7'b0010111;

   // ALU operation classes; R/I classes are refined later by funct fields
   localparam logic [CPU_ALUOP_W-1:0] ALUOP_ADD = 2'b00;
   localparam logic [CPU_ALUOP_W-1:0] ALUOP_BR  = 2'b01;
   localparam logic [CPU_ALUOP_W-1:0] ALUOP_R   = 2'b10;
   localparam logic [CPU_ALUOP_W-1:0] ALUOP_I   = 2'b11;

   typedef struct packed {
      logic [CPU_ALUOP_W-1:0] alu_op;
      logic                   alu_src;
      logic                   reg_w;
      logic                   mem_w;
      logic                   mem_r;
      logic                   mem_to_reg;
      logic                   branch;
      logic                   jump;
      logic                   illegal;
   } ctrl_t;

   // All-zero bundle: no architectural side effects
   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode-to-control-bundle mapping. Unknown opcodes
// yield the NOP bundle with the illegal flag raised; gating by instruction
// validity is left to the caller.
module control_decode
   import cpu_pkg::*;
(
   input  logic [CPU_OPCODE_W-1:0] opcode,
   output ctrl_t                   ctrl
);

   // Opcode lookup; default covers every unrecognised encoding
   always_comb begin
      ctrl         = CTRL_NOP;
      ctrl.illegal = 1'b1;
      unique case (opcode)
         OPC_LOAD: begin
            ctrl            = CTRL_NOP;
            ctrl.alu_op     = ALUOP_ADD;
            ctrl.alu_src    = 1'b1;
            ctrl.reg_w      = 1'b1;
            ctrl.mem_r      = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OPC_STORE: begin
            ctrl         = CTRL_NOP;
            ctrl.alu_op  = ALUOP_ADD;
            ctrl.alu_src = 1'b1;
            ctrl.mem_w   = 1'b1;
         end
         OPC_OP, OPC_OP32: begin
            ctrl        = CTRL_NOP;
            ctrl.alu_op = ALUOP_R;
            ctrl.reg_w  = 1'b1;
         end
         OPC_OPIMM, OPC_OPIMM32: begin
            ctrl         = CTRL_NOP;
            ctrl.alu_op  = ALUOP_I;
            ctrl.alu_src = 1'b1;
            ctrl.reg_w   = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl        = CTRL_NOP;
            ctrl.alu_op = ALUOP_BR;
            ctrl.branch = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            // ALU forms the target address; rd receives the link value
            ctrl         = CTRL_NOP;
            ctrl.alu_op  = ALUOP_ADD;
            ctrl.alu_src = 1'b1;
            ctrl.reg_w   = 1'b1;
            ctrl.jump    = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            ctrl         = CTRL_NOP;
            ctrl.alu_op  = ALUOP_ADD;
            ctrl.alu_src = 1'b1;
            ctrl.reg_w   = 1'b1;
         end
         default: begin
            ctrl         = CTRL_NOP;
            ctrl.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Main decoder: combinational opcode decode, gated by in_valid, captured in
// a single decode register that feeds execute.
module control_unit
   import cpu_pkg::*;
#(
   parameter int OPCODE_W = 7,
   parameter int ALUOP_W  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [OPCODE_W-1:0] opcode,
   output logic [ALUOP_W-1:0]  ctrl_ALU_op,
   output logic                ctrl_ALU_src,
   output logic                ctrl_reg_w,
   output logic                ctrl_mem_w,
   output logic                ctrl_mem_r,
   output logic                ctrl_mem_to_reg,
   output logic                ctrl_branch,
   output logic                ctrl_jump,
   output logic                ctrl_illegal
);

   ctrl_t dec_ctrl;
   ctrl_t nxt_ctrl;
   ctrl_t ctrl_q;

   control_decode u_decode (
      .opcode (opcode),
      .ctrl   (dec_ctrl)
   );

   // Bubbles become NOPs; an invalid slot never reports an illegal opcode
   always_comb begin
      nxt_ctrl = CTRL_NOP;
      if (in_valid) nxt_ctrl = dec_ctrl;
   end

   // Decode register; reset clears to the NOP bundle and drops pending decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ctrl_q <= CTRL_NOP;
      else        ctrl_q <= nxt_ctrl;
   end

   assign ctrl_ALU_op     = ctrl_q.alu_op;
   assign ctrl_ALU_src    = ctrl_q.alu_src;
   assign ctrl_reg_w      = ctrl_q.reg_w;
   assign ctrl_mem_w      = ctrl_q.mem_w;
   assign ctrl_mem_r      = ctrl_q.mem_r;
   assign ctrl_mem_to_reg = ctrl_q.mem_to_reg;
   assign ctrl_branch     = ctrl_q.branch;
   assign ctrl_jump       = ctrl_q.jump;
   assign ctrl_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit. Expected bundles are packed as
// {ALU_op[1:0], ALU_src, reg_w, mem_w, mem_r, mem_to_reg, branch, jump, illegal}.
module tb_control_unit;

   typedef struct {
      int         cyc;
      logic [9:0] exp;
      string      name;
   } exp_t;

   localparam logic [9:0] E_NOP    = 10'b00_0_0_0_0_0_0_0_0;
   localparam logic [9:0] E_LOAD   = 10'b00_1_1_0_1_1_0_0_0;
   localparam logic [9:0] E_STORE  = 10'b00_1_0_1_0_0_0_0_0;
   localparam logic [9:0] E_ARITH  = 10'b10_0_1_0_0_0_0_0_0;
   localparam logic [9:0] E_OPIMM  = 10'b11_1_1_0_0_0_0_0_0;
   localparam logic [9:0] E_BRANCH = 10'b01_0_0_0_0_0_1_0_0;
   localparam logic [9:0] E_JUMP   = 10'b00_1_1_0_0_0_0_1_0;
   localparam logic [9:0] E_UPPER  = 10'b00_1_1_0_0_0_0_0_0;
   localparam logic [9:0] E_ILL    = 10'b00_0_0_0_0_0_0_0_1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [6:0] opcode;
   logic [1:0] ctrl_ALU_op;
   logic       ctrl_ALU_src, ctrl_reg_w, ctrl_mem_w, ctrl_mem_r;
   logic       ctrl_mem_to_reg, ctrl_branch, ctrl_jump, ctrl_illegal;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   control_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .opcode          (opcode),
      .ctrl_ALU_op     (ctrl_ALU_op),
      .ctrl_ALU_src    (ctrl_ALU_src),
      .ctrl_reg_w      (ctrl_reg_w),
      .ctrl_mem_w      (ctrl_mem_w),
      .ctrl_mem_r      (ctrl_mem_r),
      .ctrl_mem_to_reg (ctrl_mem_to_reg),
      .ctrl_branch     (ctrl_branch),
      .ctrl_jump       (ctrl_jump),
      .ctrl_illegal    (ctrl_illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [9:0] actual();
      return {ctrl_ALU_op, ctrl_ALU_src, ctrl_reg_w, ctrl_mem_w, ctrl_mem_r,
              ctrl_mem_to_reg, ctrl_branch, ctrl_jump, ctrl_illegal};
   endfunction

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Drive one opcode before the next rising edge; its bundle is due after that edge
   task automatic issue(input string name, input logic v, input logic [6:0] op,
                        input logic [9:0] exp);
      exp_t e;
      @(negedge clk);
      in_valid = v;
      opcode   = op;
      e.cyc  = cyc + 1;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expected bundles never observed", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: after each edge, compare any bundle scheduled for this cycle
   initial begin
      forever begin
         @(posedge clk);
         #1;
         while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
               total++;
               bad++;
               $display("FAIL %s: sampled late at cycle %0d, due %0d", e.name, cyc, e.cyc);
            end else begin
               check(e.name, actual(), e.exp);
            end
         end
         if (rst_n === 1'b1 && ((ctrl_mem_w && ctrl_reg_w) || (ctrl_mem_r && !ctrl_mem_to_reg))) begin
            total++;
            bad++;
            $display("FAIL invariant: bundle %b", actual());
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b1;
      opcode   = 7'b0110011;
      repeat (3) @(posedge clk);
      #1 check("reset_hold", actual(), E_NOP);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      issue("load",  1'b1, 7'b0000011, E_LOAD);
      issue("store", 1'b1, 7'b0100011, E_STORE);
      issue("arith", 1'b1, 7'b0110011, E_ARITH);
      issue("branch",1'b1, 7'b1100011, E_BRANCH);
      issue("jal",   1'b1, 7'b1101111, E_JUMP);
      issue("bubble",1'b0, 7'b0000011, E_NOP);
      issue("jalr",  1'b1, 7'b1100111, E_JUMP);
      issue("op32",  1'b1, 7'b0111011, E_ARITH);
      issue("opimm", 1'b1, 7'b0010011, E_OPIMM);
      issue("opimm32",1'b1,7'b0011011, E_OPIMM);
      issue("lui",   1'b1, 7'b0110111, E_UPPER);
      issue("auipc", 1'b1, 7'b0010111, E_UPPER);
      issue("ill_7f",1'b1, 7'b1111111, E_ILL);
      issue("ill_inv",1'b0,7'b1111111, E_NOP);
      issue("ill_00",1'b1, 7'b0000000, E_ILL);
      issue("b2b_load",  1'b1, 7'b0000011, E_LOAD);
      issue("b2b_store", 1'b1, 7'b0100011, E_STORE);
      issue("b2b_arith", 1'b1, 7'b0110011, E_ARITH);
      issue("b2b_branch",1'b1, 7'b1100011, E_BRANCH);
      issue("pre_rst_load",1'b1,7'b0000011, E_LOAD);
      drain();

      // Asynchronous reset mid-cycle while a LOAD bundle is held
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_clear", actual(), E_NOP);
      repeat (2) @(posedge clk);
      #1 check("reset_discard", actual(), E_NOP);
      @(negedge clk);
      rst_n = 1'b1;
      issue("post_rst_store", 1'b1, 7'b0100011, E_STORE);
      issue("idle", 1'b0, 7'b0100011, E_NOP);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
